// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: operation codes, FSM states
// and a small helper that classifies operation codes.
package shift_seq_pkg;

  typedef logic [2:0] sh_type_t;

  localparam sh_type_t SH_ROL = 3'd0;
  localparam sh_type_t SH_ROR = 3'd1;
  localparam sh_type_t SH_SHL = 3'd2;
  localparam sh_type_t SH_ASR = 3'd3;
  localparam sh_type_t SH_LSR = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic type_valid(input sh_type_t t);
    return t <= SH_LSR;
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle between a requester (master) and the shift
// sequencer (slave).
interface shift_seq_if #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [2:0]        sh_type;
  logic [AMT_W-1:0]  amount;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;

  modport master (
    output start, data_in, sh_type, amount, abort,
    input  busy, done, err, result
  );

  modport slave (
    input  start, data_in, sh_type, amount, abort,
    output busy, done, err, result
  );
endinterface

// File: rtl/shift_seq_shifter.sv
// Single-bit combinational shifter; unknown codes pass the data through.
module shifter
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  sh_type_t          sh_type,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = data;
    case (sh_type)
      SH_ROL:  out = {data[DATA_W-2:0], data[DATA_W-1]};
      SH_ROR:  out = {data[0], data[DATA_W-1:1]};
      SH_SHL:  out = {data[DATA_W-2:0], 1'b0};
      SH_ASR:  out = {data[DATA_W-1], data[DATA_W-1:1]};
      SH_LSR:  out = {1'b0, data[DATA_W-1:1]};
      default: out = data;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: applies one single-bit step per clock to a
// captured operand, with abort and an invalid-operation flag.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_seq_if.slave  bus
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  sh_type_t          type_q, type_d;
  logic [DATA_W-1:0] step_out;

  shifter #(.DATA_W(DATA_W)) u_shifter (
    .data    (result_q),
    .sh_type (type_q),
    .out     (step_out)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          result_d = bus.data_in;
          type_d   = bus.sh_type;
          cnt_d    = bus.amount;
          if (bus.amount == '0 || !type_valid(bus.sh_type)) state_d = ST_DONE;
          else                                              state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The step on the aborting edge still lands, leaving the partial value.
        if (type_valid(type_q)) result_d = step_out;
        cnt_d = cnt_q - AMT_W'(1);
        if (bus.abort)                  state_d = ST_IDLE;
        else if (cnt_q == AMT_W'(1))    state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      type_q   <= SH_ROL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.err    = (state_q == ST_DONE) && !type_valid(type_q);
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vector table, hand-written
// corner sequences and randomized operations against a behavioural model.
module tb_shift_seq;
  import shift_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shift_seq_if #(.DATA_W(8), .AMT_W(3)) bus ();

  shift_seq #(.DATA_W(8), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [2:0] amt;
    logic [7:0] exp_result;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  // Reference: rotate/shift on plain integers, one step per unit of amount.
  function automatic logic [7:0] modelResult(input logic [2:0] op, input logic [7:0] data,
                                             input logic [2:0] amt);
    int v = int'(data);
    if (op > 3'd4) return data;
    for (int i = 0; i < int'(amt); i++) begin
      case (op)
        3'd0: v = ((v * 2) + (v / 128)) % 256;
        3'd1: v = (v / 2) + ((v % 2) * 128);
        3'd2: v = (v * 2) % 256;
        3'd3: v = (v / 2) + (v >= 128 ? 128 : 0);
        default: v = v / 2;
      endcase
    end
    return v[7:0];
  endfunction

  function automatic int modelLatency(input logic [2:0] op, input logic [2:0] amt);
    return (op > 3'd4 || amt == 3'd0) ? 1 : int'(amt) + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data,
                               input logic [2:0] amt, input logic with_abort);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = data;
    bus.sh_type = op;
    bus.amount  = amt;
    bus.abort   = with_abort;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.data_in = 8'($urandom);
    bus.sh_type = 3'($urandom);
    bus.amount  = 3'($urandom);
  endtask

  // Called right after an accept edge; follows the operation to its done pulse.
  task automatic runAndCheck(input string name, input logic [7:0] exp_result,
                             input logic exp_err, input int exp_lat);
    int   lat = -1;
    int   busy_low = 0;
    logic err_seen = 1'bx;
    logic [7:0] res_seen = 8'hxx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat      = c;
        err_seen = bus.err;
        res_seen = bus.result;
        break;
      end
      if (bus.busy !== 1'b1) busy_low++;
    end
    checkOutput({name, " latency"}, lat, exp_lat);
    checkOutput({name, " busy"}, busy_low, 0);
    checkOutput({name, " err"}, {31'd0, err_seen}, {31'd0, exp_err});
    checkOutput({name, " result"}, {24'd0, res_seen}, {24'd0, exp_result});
    @(negedge clk);
    checkOutput({name, " done width"}, {30'd0, bus.done, bus.busy}, 32'd0);
    checkOutput({name, " result hold"}, {24'd0, bus.result}, {24'd0, exp_result});
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] data;

    vecs[0] = '{SH_ROL, 8'h81, 3'd3, 8'h0C, 1'b0, 4};
    vecs[1] = '{SH_ASR, 8'h80, 3'd7, 8'hFF, 1'b0, 8};
    vecs[2] = '{SH_LSR, 8'h80, 3'd7, 8'h01, 1'b0, 8};
    vecs[3] = '{SH_ROR, 8'h01, 3'd1, 8'h80, 1'b0, 2};
    vecs[4] = '{SH_SHL, 8'h5A, 3'd0, 8'h5A, 1'b0, 1};
    vecs[5] = '{3'd6,   8'h3C, 3'd5, 8'h3C, 1'b1, 1};
    vecs[6] = '{SH_SHL, 8'h01, 3'd7, 8'h80, 1'b0, 8};
    vecs[7] = '{SH_ROR, 8'h81, 3'd2, 8'h60, 1'b0, 3};
    vecs[8] = '{3'd7,   8'hA5, 3'd0, 8'hA5, 1'b1, 1};

    bus.start = 1'b0; bus.abort = 1'b0; bus.data_in = '0; bus.sh_type = '0; bus.amount = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset outputs", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    checkOutput("reset result", {24'd0, bus.result}, 32'd0);

    // First accept on the very first rising edge after release.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1; bus.data_in = vecs[0].data; bus.sh_type = vecs[0].op; bus.amount = vecs[0].amt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("first accept busy", {31'd0, bus.busy}, 32'd1);
    runAndCheck("vec0", vecs[0].exp_result, vecs[0].exp_err, vecs[0].exp_lat);

    for (int i = 1; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].amt, 1'b0);
      runAndCheck($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Second start while busy must be dropped.
    applyStimulus(SH_ROL, 8'h81, 3'd3, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = 8'hFF; bus.sh_type = SH_SHL; bus.amount = 3'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    countDones(10, n);
    checkOutput("busy start done count", n, 1);
    checkOutput("busy start result", {24'd0, bus.result}, 32'h0C);

    // Start held through DONE is ignored there, accepted on the next edge.
    applyStimulus(SH_SHL, 8'h5A, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("b2b first done", {31'd0, bus.done}, 32'd1);
    bus.start = 1'b1; bus.data_in = 8'h01; bus.sh_type = SH_ROR; bus.amount = 3'd1;
    @(posedge clk);
    #1;
    checkOutput("b2b ignored in done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b accepted", {31'd0, bus.busy}, 32'd1);
    runAndCheck("b2b", 8'h80, 1'b0, 2);

    // Abort in the second SHIFT cycle.
    applyStimulus(SH_SHL, 8'h01, 3'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort result", {24'd0, bus.result}, 32'h04);
    countDones(8, n);
    checkOutput("abort no done", n, 0);

    // Abort alone in IDLE does nothing; with start, start wins.
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    checkOutput("idle abort", {31'd0, bus.busy}, 32'd0);
    applyStimulus(SH_LSR, 8'hF0, 3'd2, 1'b1);
    runAndCheck("start beats abort", 8'h3C, 1'b0, 3);

    // Asynchronous reset in the middle of a shift.
    applyStimulus(SH_SHL, 8'h01, 3'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset outputs", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    checkOutput("mid reset result", {24'd0, bus.result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    countDones(8, n);
    checkOutput("post reset no done", n, 0);
    applyStimulus(SH_ROL, 8'h01, 3'd1, 1'b0);
    runAndCheck("post reset rol", 8'h02, 1'b0, 2);

    for (int i = 0; i < 30; i++) begin
      op   = 3'($urandom_range(0, 7));
      data = 8'($urandom);
      amt  = 3'($urandom);
      applyStimulus(op, data, amt, 1'b0);
      runAndCheck($sformatf("rand%0d op%0d d%0h a%0d", i, op, data, amt),
                  modelResult(op, data, amt), (op > 3'd4), modelLatency(op, amt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
